// File: rtl/rcv_block_fifo.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a
// receive FIFO whose entries carry a per-word parity tag.
module rcv_block_fifo #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 10,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_in,
   input  logic                          data_read,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          data_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_error,
   output logic                          framing_error,
   output logic                          overrun_error
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int CNTW = AW + 1;
   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int EW   = DATA_BITS + 1;
   localparam logic PAR_ODD = 1'(PARITY_ODD);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_DATA      = 3'd2,
      S_PARITY    = 3'd3,
      S_STOP      = 3'd4,
      S_PUSH      = 3'd5,
      S_WAIT_HIGH = 3'd6
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q, sync2_q;
   logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bad_q, par_bad_d;
   logic                 framing_q, framing_d;
   logic                 overrun_q, overrun_d;
   logic [EW-1:0]        mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]      count_q, count_d;

   logic                 line_s;
   logic                 half_tick_s;
   logic                 bit_tick_s;
   logic                 pop_s;
   logic                 full_s;
   logic                 push_s;
   logic [EW-1:0]        head_s;

   assign line_s      = sync2_q;
   assign half_tick_s = (clk_cnt_q == CW'(CLKS_PER_BIT/2 - 1));
   assign bit_tick_s  = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
   assign pop_s       = data_read && (count_q != CNTW'(0));
   assign full_s      = (count_q == CNTW'(FIFO_DEPTH));
   // A full FIFO still accepts the new word when the head leaves in the same cycle.
   assign push_s      = (state_q == S_PUSH) && (!full_s || pop_s);
   assign head_s      = mem_q[rd_ptr_q];

   // Receive FSM next-state, sampling and sticky-flag logic.
   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q + CW'(1);
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_bad_d = par_bad_q;
      framing_d = framing_q;
      if (pop_s) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
      case (state_q)
         S_IDLE: begin
            clk_cnt_d = CW'(0);
            if (!line_s) begin
               state_d   = S_START;
               bit_cnt_d = 4'd0;
               framing_d = 1'b0;
               par_bad_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_START: begin
            if (half_tick_s) begin
               clk_cnt_d = CW'(0);
               if (line_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
               end
            end else begin
               state_d = S_START;
            end
         end
         S_DATA: begin
            if (bit_tick_s) begin
               clk_cnt_d = CW'(0);
               shift_d   = {line_s, shift_q[DATA_BITS-1:1]};
               if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                  bit_cnt_d = 4'd0;
                  if (PARITY_EN != 0) begin
                     state_d = S_PARITY;
                  end else begin
                     state_d = S_STOP;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               state_d = S_DATA;
            end
         end
         S_PARITY: begin
            if (bit_tick_s) begin
               clk_cnt_d = CW'(0);
               par_bad_d = ((^shift_q) ^ line_s) != PAR_ODD;
               state_d   = S_STOP;
            end else begin
               state_d = S_PARITY;
            end
         end
         S_STOP: begin
            if (bit_tick_s) begin
               clk_cnt_d = CW'(0);
               if (!line_s) begin
                  framing_d = 1'b1;
                  state_d   = S_WAIT_HIGH;
               end else if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                  bit_cnt_d = 4'd0;
                  state_d   = S_PUSH;
               end else begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end else begin
               state_d = S_STOP;
            end
         end
         S_PUSH: begin
            state_d = S_IDLE;
            if (!push_s) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q && !pop_s;
            end
         end
         S_WAIT_HIGH: begin
            clk_cnt_d = CW'(0);
            if (line_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT_HIGH;
            end
         end
         default: begin
            state_d   = S_IDLE;
            clk_cnt_d = CW'(0);
         end
      endcase
   end

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   // Head-of-FIFO outputs, forced to zero while the FIFO is empty.
   always_comb begin
      data_ready    = (count_q != CNTW'(0));
      fifo_count    = count_q;
      framing_error = framing_q;
      overrun_error = overrun_q;
      if (data_ready) begin
         rx_data      = head_s[DATA_BITS-1:0];
         parity_error = head_s[DATA_BITS];
      end else begin
         rx_data      = '0;
         parity_error = 1'b0;
      end
   end

   // State, synchroniser and FIFO storage registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         clk_cnt_q <= CW'(0);
         bit_cnt_q <= 4'd0;
         shift_q   <= '0;
         par_bad_q <= 1'b0;
         framing_q <= 1'b0;
         overrun_q <= 1'b0;
         wr_ptr_q  <= AW'(0);
         rd_ptr_q  <= AW'(0);
         count_q   <= CNTW'(0);
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         sync1_q   <= serial_in;
         sync2_q   <= sync1_q;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_bad_q <= par_bad_d;
         framing_q <= framing_d;
         overrun_q <= overrun_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         if (push_s) begin
            mem_q[wr_ptr_q] <= {par_bad_q, shift_q};
         end
      end
   end

endmodule

// File: doc/rcv_block_fifo.md
Name: rcv_block_fifo

Overview:
Parametrised UART receiver, successor to the fixed 8N1 receive block. Configurable data width, bit period, parity and stop bits. Received words land in an internal FIFO so several frames can arrive before software reads. Sits between the serial pin and the bus-side register interface; per-word error tagging replaces the single-word load buffer.

Parameters:
DATA_BITS, 8, data bits per frame (5..9), LSB first
CLKS_PER_BIT, 10, clk cycles per serial bit (>=4, even)
PARITY_EN, 0, 1 = parity bit follows data
PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)
STOP_BITS, 1, number of stop bits checked (1 or 2)
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
serial_in  in  1  asynchronous serial line, idle high
data_read  in  1  pop request; pops head when data_ready=1
rx_data  out  DATA_BITS  head FIFO word (0 when empty)
data_ready  out  1  FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries held
parity_error  out  1  parity tag of head word (0 when empty)
framing_error  out  1  sticky: last frame had a bad stop bit
overrun_error  out  1  sticky: frame dropped because FIFO was full

Behaviour:
- Reset (async, rst=1): all outputs 0, FIFO empty, FSM IDLE, synchroniser flops set to 1.
- serial_in passes through a 2-flop synchroniser; all logic uses the synchronised value.
- FSM states: IDLE, START, DATA, PARITY, STOP, PUSH, WAIT_HIGH.
- IDLE: sync line = 0 -> START, bit counter cleared; framing_error cleared at this transition.
- START: after CLKS_PER_BIT/2 cycles, sample line; 0 -> DATA; 1 -> IDLE (glitch rejected, nothing recorded).
- DATA: sample every CLKS_PER_BIT cycles; DATA_BITS samples shifted in LSB first -> PARITY if PARITY_EN, else STOP.
- PARITY: one sample; parity_bad = (XOR(data) ^ sample) != PARITY_ODD.
- STOP: STOP_BITS samples, one per CLKS_PER_BIT. Any stop sample 0 -> framing_error=1, frame discarded, -> WAIT_HIGH. All 1 -> PUSH.
- WAIT_HIGH: stay until sync line = 1, then IDLE (a held-low break never produces frames).
- PUSH (one cycle): if FIFO not full, or full with a pop in the same cycle, write {parity_bad, data}; else drop frame, overrun_error=1. -> IDLE.
- Sampling point is mid-bit: start + k*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles after start detection; tolerates ±4% rate error at 10-bit frames.
- FIFO: pop when data_read & data_ready (level-sensitive, one pop per cycle held high). rx_data/parity_error are combinational from the head entry. Simultaneous push and pop: count unchanged, both take effect.
- data_ready/fifo_count update the cycle after PUSH.
- overrun_error clears on any accepted pop. framing_error clears on next start detection or reset only.
- Pop on empty FIFO: ignored, no state change. Read/write pointers wrap modulo FIFO_DEPTH.
- Reset mid-frame: frame abandoned, FIFO flushed, FSM returns to IDLE.

Test Plan:
- Defaults, 10 ns clk, 100 ns bits, send 0x05 stop=1 -> data_ready=1, rx_data=0x05, fifo_count=1, no errors; pulse data_read 1 cycle -> count=0, data_ready=0.
- Bit period 96 ns then 104 ns, send 0x0A then 0x32 without reading -> fifo_count=2, head 0x0A, after one pop head 0x32.
- Send 0xE3 with stop=0, line held low 300 ns then high -> framing_error=1, fifo_count unchanged; next good frame 0x33 -> framing_error=0, 0x33 stored.
- Send 5 frames 0x10..0x14, no reads -> fifo_count=4, overrun_error=1, head 0x10; pop -> overrun_error=0, head 0x11; 0x14 never appears.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_error=1 with head 0x07; send 0x07 parity 1 -> second entry parity_error=0.
- 30 ns low glitch on idle line -> no frame, no flags; rst pulse mid-DATA -> all outputs 0, next frame 0x55 received correctly.
